// File: rtl/axi4_master_rd_burst_gen.sv
// ---------------------------------------------------------------------------
// axi4_master_rd_burst_gen
//   Read command engine. Accepts a (start address, total beats, id) command
//   and splits it into INCR bursts of at most MAX_BURST_BEATS that never
//   cross a 4KB page. Each burst goes out as one packed AR packet. Returning
//   R packets are unpacked and passed straight through to the consumer. When
//   the last beat is taken, a one-cycle done pulse reports the worst RRESP.
//
// Ports
//   aclk, areset        clock, asynchronous active-high reset
//   cmd_*               command handshake: byte address, beat count, ARID
//   fub_axi_ar*         packed AR channel towards the master stub
//   fub_axi_r*          packed R channel from the master stub
//   data_*              beat stream to the consumer (data_last = final beat)
//   done_valid/resp     completion pulse and worst response of the command
//   busy                high from command accept until done_valid
// ---------------------------------------------------------------------------
module axi4_master_rd_burst_gen #(
    parameter int AXI_ID_WIDTH    = 8,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int AXI_USER_WIDTH  = 1,
    parameter int MAX_BURST_BEATS = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int LEN_WIDTH       = 16,
    parameter int ARSize          = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 29 + AXI_USER_WIDTH,
    parameter int RSize           = AXI_ID_WIDTH + AXI_DATA_WIDTH + 3 + AXI_USER_WIDTH
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]      cmd_beats,
    input  logic [AXI_ID_WIDTH-1:0]   cmd_id,
    output logic                      fub_axi_arvalid,
    input  logic                      fub_axi_arready,
    output logic [ARSize-1:0]         fub_axi_ar_pkt,
    input  logic                      fub_axi_rvalid,
    output logic                      fub_axi_rready,
    input  logic [RSize-1:0]          fub_axi_r_pkt,
    output logic                      data_valid,
    input  logic                      data_ready,
    output logic [AXI_DATA_WIDTH-1:0] data_out,
    output logic                      data_last,
    output logic                      done_valid,
    output logic [1:0]                done_resp,
    output logic                      busy
);

    localparam int unsigned SZ = $clog2(AXI_DATA_WIDTH / 8);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int IW = AXI_ID_WIDTH;
    localparam int DW = AXI_DATA_WIDTH;
    localparam int UW = AXI_USER_WIDTH;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                    r_state;
    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]      r_remaining;
    logic [LEN_WIDTH-1:0]      r_cmd_beats;
    logic [LEN_WIDTH-1:0]      r_rx_count;
    logic [IW-1:0]             r_id;
    logic [OW-1:0]             r_outstanding;
    logic [1:0]                r_resp;
    logic [1:0]                r_done_resp;
    logic                      r_done_valid;
    logic                      r_busy;
    logic                      r_arvalid;
    logic [ARSize-1:0]         r_ar_pkt;
    logic [8:0]                r_cur_beats;

    logic [IW-1:0]             w_r_id;
    logic [DW-1:0]             w_r_data;
    logic [1:0]                w_r_resp;
    logic                      w_r_last;
    logic [UW-1:0]             w_r_user;
    logic                      w_unused_user;
    logic                      w_r_hs;
    logic                      w_ar_hs;
    logic                      w_final_beat;
    logic [12:0]               w_page_beats;
    logic [31:0]               w_beats;
    logic [1:0]                w_resp_beat;
    logic [1:0]                w_resp_acc;

    // R packet layout: {id, data, resp, last, user}
    assign w_r_id        = fub_axi_r_pkt[RSize-1 -: IW];
    assign w_r_data      = fub_axi_r_pkt[UW+3 +: DW];
    assign w_r_resp      = fub_axi_r_pkt[UW+1 +: 2];
    assign w_r_last      = fub_axi_r_pkt[UW];
    assign w_r_user      = fub_axi_r_pkt[UW-1:0];
    assign w_unused_user = ^w_r_user;

    assign cmd_ready       = (r_state == IDLE) & ~areset;
    assign fub_axi_arvalid = r_arvalid;
    assign fub_axi_ar_pkt  = r_ar_pkt;
    assign data_valid      = fub_axi_rvalid & r_busy;
    assign fub_axi_rready  = data_ready & r_busy;
    assign data_out        = w_r_data;
    assign data_last       = r_busy & (r_rx_count == r_cmd_beats - LEN_WIDTH'(1));
    assign done_valid      = r_done_valid;
    assign done_resp       = r_done_resp;
    assign busy            = r_busy;

    assign w_r_hs       = fub_axi_rvalid & fub_axi_rready;
    assign w_ar_hs      = r_arvalid & fub_axi_arready;
    assign w_final_beat = w_r_hs & (r_rx_count == r_cmd_beats - LEN_WIDTH'(1));

    // Beats left before the next 4KB boundary
    assign w_page_beats = (13'd4096 - {1'b0, r_addr[11:0]}) >> SZ;

    always_comb begin
        w_beats = 32'(w_page_beats);
        if (32'(MAX_BURST_BEATS) < w_beats) w_beats = 32'(MAX_BURST_BEATS);
        if (32'(r_remaining) < w_beats)     w_beats = 32'(r_remaining);
    end

    // An ID mismatch raises the beat's contribution to at least SLVERR
    always_comb begin
        w_resp_beat = w_r_resp;
        if (w_r_id != r_id && w_r_resp < 2'b10) w_resp_beat = 2'b10;
        w_resp_acc = (w_resp_beat > r_resp) ? w_resp_beat : r_resp;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state       <= IDLE;
            r_addr        <= '0;
            r_remaining   <= '0;
            r_cmd_beats   <= '0;
            r_rx_count    <= '0;
            r_id          <= '0;
            r_outstanding <= '0;
            r_resp        <= '0;
            r_done_resp   <= '0;
            r_done_valid  <= 1'b0;
            r_busy        <= 1'b0;
            r_arvalid     <= 1'b0;
            r_ar_pkt      <= '0;
            r_cur_beats   <= '0;
        end else begin
            if (w_ar_hs && !(w_r_hs && w_r_last))
                r_outstanding <= r_outstanding + OW'(1);
            else if (!w_ar_hs && w_r_hs && w_r_last)
                r_outstanding <= r_outstanding - OW'(1);

            if (w_r_hs) begin
                r_rx_count <= r_rx_count + LEN_WIDTH'(1);
                r_resp     <= w_resp_acc;
            end

            case (r_state)
                IDLE: begin
                    r_done_valid <= 1'b0;
                    if (cmd_valid) begin
                        r_addr      <= cmd_addr & ~(AXI_ADDR_WIDTH'(DW / 8 - 1));
                        r_remaining <= cmd_beats;
                        r_cmd_beats <= cmd_beats;
                        r_id        <= cmd_id;
                        r_rx_count  <= '0;
                        r_resp      <= '0;
                        if (cmd_beats == '0) begin
                            r_state      <= DONE;
                            r_done_valid <= 1'b1;
                            r_done_resp  <= '0;
                        end else begin
                            r_state <= ISSUE;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    // Burst parameters are latched with arvalid so the
                    // packet stays stable while the stub back-pressures.
                    if (!r_arvalid) begin
                        if (r_outstanding < OW'(MAX_OUTSTANDING)) begin
                            r_arvalid   <= 1'b1;
                            r_cur_beats <= 9'(w_beats);
                            r_ar_pkt    <= {r_id, r_addr, 8'(w_beats - 32'd1), 3'(SZ),
                                            2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000,
                                            4'b0000, {UW{1'b0}}};
                        end
                    end else if (fub_axi_arready) begin
                        r_arvalid   <= 1'b0;
                        r_addr      <= r_addr + (AXI_ADDR_WIDTH'(r_cur_beats) << SZ);
                        r_remaining <= r_remaining - LEN_WIDTH'(r_cur_beats);
                        if (r_remaining == LEN_WIDTH'(r_cur_beats)) r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_final_beat) begin
                        r_state      <= DONE;
                        r_done_valid <= 1'b1;
                        r_busy       <= 1'b0;
                        r_done_resp  <= w_resp_acc;
                    end
                end
                DONE: begin
                    r_done_valid <= 1'b0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_master_rd_burst_gen.sv
// ---------------------------------------------------------------------------
// tb_axi4_master_rd_burst_gen
//   Drives commands into axi4_master_rd_burst_gen and plays the AXI stub on
//   the packed AR/R side with random back-pressure. Expected bursts come from
//   the page/size splitting rule; expected beats, last flag, response and
//   completion timing come from a per-command beat plan.
// ---------------------------------------------------------------------------
module tb_axi4_master_rd_burst_gen;

    localparam int IW   = 8;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int UW   = 1;
    localparam int MAXB = 16;
    localparam int MAXO = 2;
    localparam int LW   = 16;
    localparam int ARS  = IW + AW + 29 + UW;
    localparam int RS   = IW + DW + 3 + UW;

    logic          clk = 1'b0;
    logic          areset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_beats;
    logic [IW-1:0] cmd_id;
    logic          fub_axi_arvalid;
    logic          fub_axi_arready;
    logic [ARS-1:0] fub_axi_ar_pkt;
    logic          fub_axi_rvalid;
    logic          fub_axi_rready;
    logic [RS-1:0] fub_axi_r_pkt;
    logic          data_valid;
    logic          data_ready;
    logic [DW-1:0] data_out;
    logic          data_last;
    logic          done_valid;
    logic [1:0]    done_resp;
    logic          busy;

    axi4_master_rd_burst_gen #(
        .AXI_ID_WIDTH   (IW),
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .AXI_USER_WIDTH (UW),
        .MAX_BURST_BEATS(MAXB),
        .MAX_OUTSTANDING(MAXO),
        .LEN_WIDTH      (LW)
    ) dut (
        .aclk           (clk),
        .areset         (areset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_addr       (cmd_addr),
        .cmd_beats      (cmd_beats),
        .cmd_id         (cmd_id),
        .fub_axi_arvalid(fub_axi_arvalid),
        .fub_axi_arready(fub_axi_arready),
        .fub_axi_ar_pkt (fub_axi_ar_pkt),
        .fub_axi_rvalid (fub_axi_rvalid),
        .fub_axi_rready (fub_axi_rready),
        .fub_axi_r_pkt  (fub_axi_r_pkt),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .data_out       (data_out),
        .data_last      (data_last),
        .done_valid     (done_valid),
        .done_resp      (done_resp),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int unsigned    n_vec = 0;
    int unsigned    n_err = 0;

    logic [ARS-1:0] exp_ar_q[$];
    int unsigned    stub_q[$];          // beats still owed per accepted AR
    logic [1:0]     plan_resp[128];
    bit             plan_bad[128];
    int unsigned    total, rx_cnt, ar_count, outst;
    logic [1:0]     exp_resp;
    logic [IW-1:0]  cur_id;
    bit             want_cmd, accepted, finished, exp_busy, done_pending;
    bit             prev_ar_wait, pres_taken;
    logic [ARS-1:0] prev_pkt;
    logic [DW-1:0]  pres_data;
    int unsigned    r_stall_cnt, ar_low_cnt, ar_low_arm;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [ARS-1:0] ar_pkt_of(input int unsigned a, input int unsigned beats,
                                                 input logic [IW-1:0] id);
        return {id, AW'(a), 8'(beats - 1), 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000,
                4'b0000, 1'b0};
    endfunction

    task automatic clear_model();
        exp_ar_q.delete();
        stub_q.delete();
        outst = 0; rx_cnt = 0; ar_count = 0; total = 0;
        want_cmd = 0; accepted = 0; finished = 0; exp_busy = 0; done_pending = 0;
        prev_ar_wait = 0; pres_taken = 0; r_stall_cnt = 0; ar_low_cnt = 0; ar_low_arm = 0;
    endtask

    // One clock: drive at the falling edge, observe 1ns later. Everything
    // observed here is what the DUT will see at the next rising edge.
    task automatic step();
        bit due_now;
        @(negedge clk);
        cmd_valid = want_cmd;
        if (pres_taken) begin
            fub_axi_rvalid = 1'b0;
            pres_taken = 0;
        end
        if (ar_low_cnt > 0) begin
            fub_axi_arready = 1'b0;
            ar_low_cnt--;
        end else begin
            fub_axi_arready = ($urandom_range(0, 3) != 0);
        end
        data_ready = ($urandom_range(0, 3) != 0);
        if (r_stall_cnt > 0) begin
            r_stall_cnt--;
        end else if (!fub_axi_rvalid && stub_q.size() > 0 && $urandom_range(0, 3) != 0) begin
            int unsigned k;
            k = (rx_cnt < 128) ? rx_cnt : 127;
            pres_data = $urandom;
            fub_axi_r_pkt = {plan_bad[k] ? ~cur_id : cur_id, pres_data, plan_resp[k],
                             stub_q[0] == 1, 1'b0};
            fub_axi_rvalid = 1'b1;
        end
        #1;
        due_now = done_pending;
        done_pending = 0;
        chk("busy", busy, exp_busy);
        chk("data_valid", data_valid, fub_axi_rvalid & exp_busy);
        chk("rready", fub_axi_rready, data_ready & exp_busy);
        chk("done_valid", done_valid, due_now);
        if (due_now) begin
            chk("done_resp", done_resp, exp_resp);
            finished = 1;
        end
        if (exp_busy) chk("cmd_ready_busy", cmd_ready, 0);
        if (prev_ar_wait) begin
            chk("arvalid_hold", fub_axi_arvalid, 1);
            chk("ar_pkt_hold", fub_axi_ar_pkt, prev_pkt);
        end
        if (fub_axi_arvalid) chk("ar_outst_lim", outst < MAXO, 1);
        if (fub_axi_arvalid && fub_axi_arready) begin
            if (exp_ar_q.size() == 0) chk("ar_unexpected", fub_axi_arvalid, 0);
            else chk("ar_pkt", fub_axi_ar_pkt, exp_ar_q.pop_front());
            stub_q.push_back(int'(fub_axi_ar_pkt[ARS-IW-AW-1 -: 8]) + 1);
            outst++;
            ar_count++;
            prev_ar_wait = 0;
        end else begin
            prev_ar_wait = fub_axi_arvalid;
            prev_pkt = fub_axi_ar_pkt;
        end
        if (fub_axi_rvalid && fub_axi_rready) begin
            chk("data_out", data_out, pres_data);
            chk("data_last", data_last, rx_cnt == total - 1);
            rx_cnt++;
            pres_taken = 1;
            if (stub_q.size() > 0) begin
                if (stub_q[0] == 1) begin
                    void'(stub_q.pop_front());
                    outst--;
                end else begin
                    stub_q[0]--;
                end
            end
            if (rx_cnt == total) begin
                done_pending = 1;
                exp_busy = 0;
            end
        end
        if (cmd_valid && cmd_ready) begin
            want_cmd = 0;
            accepted = 1;
            ar_low_cnt = ar_low_arm;
            if (total == 0) done_pending = 1;
            else exp_busy = 1;
        end
    endtask

    task automatic start_cmd(input logic [AW-1:0] addr, input int unsigned beats,
                             input logic [IW-1:0] id, input int unsigned stall,
                             input int unsigned arlow, input int err_beat, input int bad_beat,
                             input bit rnd_resp);
        int unsigned a, rem, b, room, n;
        logic [1:0] r;
        exp_ar_q.delete();
        a = addr & ~32'h3;
        rem = beats;
        while (rem > 0) begin
            room = (4096 - (a % 4096)) / 4;
            b = rem;
            if (b > MAXB) b = MAXB;
            if (b > room) b = room;
            exp_ar_q.push_back(ar_pkt_of(a, b, id));
            a += 4 * b;
            rem -= b;
        end
        exp_resp = 2'b00;
        for (int k = 0; k < 128; k++) begin
            if (k == err_beat) plan_resp[k] = 2'b10;
            else if (rnd_resp && $urandom_range(0, 7) == 0) plan_resp[k] = 2'($urandom_range(0, 3));
            else plan_resp[k] = 2'b00;
            plan_bad[k] = (k == bad_beat);
            r = plan_resp[k];
            if (plan_bad[k] && r < 2'b10) r = 2'b10;
            if (k < int'(beats) && r > exp_resp) exp_resp = r;
        end
        total = beats; rx_cnt = 0; ar_count = 0; cur_id = id;
        cmd_addr = addr; cmd_beats = LW'(beats); cmd_id = id;
        r_stall_cnt = stall; ar_low_arm = arlow;
        accepted = 0; finished = 0; want_cmd = 1;
        n = 0;
        while (!accepted && n < 100) begin
            step();
            n++;
        end
        if (!accepted) chk("accept_timeout", accepted, 1);
    endtask

    task automatic finish_cmd();
        int unsigned n;
        n = 0;
        while (!finished && n < 4000) begin
            step();
            n++;
        end
        if (!finished) chk("done_timeout", finished, 1);
        chk("ar_all_issued", exp_ar_q.size(), 0);
        chk("beats_rx", rx_cnt, total);
        step();
    endtask

    task automatic run_cmd(input logic [AW-1:0] addr, input int unsigned beats,
                           input int unsigned stall, input int unsigned arlow,
                           input int err_beat, input int bad_beat, input bit rnd_resp);
        start_cmd(addr, beats, IW'($urandom), stall, arlow, err_beat, bad_beat, rnd_resp);
        finish_cmd();
    endtask

    initial begin
        int unsigned n;
        logic [AW-1:0] a;
        int unsigned bt;
        clear_model();
        areset = 1'b1;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0; cmd_id = '0;
        fub_axi_arready = 1'b1; fub_axi_rvalid = 1'b1; fub_axi_r_pkt = '0; data_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_arvalid", fub_axi_arvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_data_last", data_last, 0);
        @(negedge clk);
        fub_axi_rvalid = 1'b0;
        areset = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_cmd_ready", cmd_ready, 1);

        // Page crossing: 0xFF0 x20 -> len 3 then len 15
        run_cmd(32'h0000_0FF0, 20, 0, 0, -1, -1, 0);
        // Three bursts 16/16/8
        run_cmd(32'h0000_0100, 40, 0, 0, -1, -1, 0);
        // R stalled: only MAXO ARs may go out
        start_cmd(32'h0000_2000, 64, IW'($urandom), 40, 0, -1, -1, 0);
        repeat (30) step();
        chk("ar_stalled_cnt", ar_count, MAXO);
        finish_cmd();
        // Error response on beat 5, then an ID mismatch on one beat
        run_cmd(32'h0000_0200, 8, 0, 0, 4, -1, 0);
        run_cmd(32'h0000_0300, 8, 0, 0, -1, 2, 0);
        // Zero-beat command
        run_cmd(32'h0000_0400, 0, 0, 0, -1, -1, 0);
        chk("zero_no_ar", ar_count, 0);
        // arready held low while arvalid is pending
        run_cmd(32'h0000_4000, 20, 0, 12, -1, -1, 0);

        // Reset with two bursts outstanding
        start_cmd(32'h0000_3000, 64, IW'($urandom), 500, 0, -1, -1, 0);
        n = 0;
        while (ar_count < 2 && n < 100) begin
            step();
            n++;
        end
        chk("ar_before_reset", ar_count, 2);
        @(negedge clk);
        areset = 1'b1;
        cmd_valid = 1'b0;
        fub_axi_rvalid = 1'b1;
        data_ready = 1'b1;
        #1;
        chk("midrst_arvalid", fub_axi_arvalid, 0);
        chk("midrst_data_valid", data_valid, 0);
        chk("midrst_busy", busy, 0);
        clear_model();
        fub_axi_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        areset = 1'b0;
        run_cmd(32'h0000_0000, 4, 0, 0, -1, -1, 0);

        // Random commands, some starting just below a page boundary
        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 2) == 0)
                a = AW'(32'h1000 * $urandom_range(0, 15) + 4096 - 4 * $urandom_range(1, 20));
            else
                a = AW'($urandom & 32'h0000_FFFF);
            bt = $urandom_range(1, 100);
            run_cmd(a, bt, $urandom_range(0, 5), 0, -1,
                    ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, bt - 1)) : -1, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
